// File: rtl/rx_ingress_arbiter.sv
// rx_ingress_arbiter: shares the packet-memory write port among NUM_PORTS
// receive MACs. Whole frames are granted round-robin, and the granted port's
// beats are forwarded to memory through one output register stage.
// Optional build macro RX_ARB_WATCHDOG_EN adds an idle-beat watchdog that
// aborts a locked frame after WDOG_CYCLES ready cycles without a beat.
module rx_ingress_arbiter #(
  parameter int NUM_PORTS   = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                            switch_clk,
  input  logic                            switch_rst_n,
  input  logic [NUM_PORTS-1:0]            rx_valid_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] rx_data_i,
  input  logic [NUM_PORTS-1:0]            rx_sof_i,
  input  logic [NUM_PORTS-1:0]            rx_eof_i,
  input  logic [NUM_PORTS-1:0]            rx_error_i,
  output logic [NUM_PORTS-1:0]            rx_grant_o,
  input  logic                            mem_ready_i,
  output logic [DATA_WIDTH-1:0]           mem_data_o,
  output logic                            mem_valid_o,
  output logic                            mem_sof_o,
  output logic                            mem_eof_o,
  output logic                            mem_error_o,
  output logic [$clog2(NUM_PORTS)-1:0]    mem_port_o
);

  localparam int PW = $clog2(NUM_PORTS);

  typedef enum logic [0:0] {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [PW-1:0]         rr_ptr, rr_ptr_nxt;
  logic [PW-1:0]         lock_port, lock_port_nxt;
  logic [NUM_PORTS-1:0]  pending, pending_nxt;
  logic [NUM_PORTS-1:0]  req, lock_mask;
  logic                  first_beat, first_beat_nxt;
  logic                  sel_found;
  logic [PW-1:0]         sel_port;
  logic                  lk_valid, lk_sof, lk_eof, lk_err;
  logic [DATA_WIDTH-1:0] lk_data;
  logic                  grant_en, accept, viol, eof_acc, wdog_trip;

  // Port index (base + off) wrapped into 0..NUM_PORTS-1.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return PW'(s);
  endfunction

  // The locked port's lane, selected out of the per-port buses.
  assign lk_valid  = rx_valid_i[lock_port];
  assign lk_sof    = rx_sof_i[lock_port];
  assign lk_eof    = rx_eof_i[lock_port];
  assign lk_err    = rx_error_i[lock_port];
  assign lk_data   = rx_data_i[lock_port*DATA_WIDTH +: DATA_WIDTH];
  assign lock_mask = NUM_PORTS'(1) << lock_port;

  // A port holding sof in IDLE is eligible in the same cycle, giving the
  // one-cycle arbitration latency without waiting for its pending bit.
  assign req = pending | rx_sof_i;

  assign grant_en   = (state == LOCK) && mem_ready_i && !wdog_trip;
  assign accept     = grant_en && lk_valid;
  assign viol       = accept && lk_sof && !first_beat;
  assign eof_acc    = accept && lk_eof && !viol;
  assign rx_grant_o = grant_en ? lock_mask : '0;

  // Round-robin search: first requesting port at or above rr_ptr, with wrap.
  always_comb begin
    sel_found = 1'b0;
    sel_port  = rr_ptr;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!sel_found && req[wrap_add(rr_ptr, i)]) begin
        sel_found = 1'b1;
        sel_port  = wrap_add(rr_ptr, i);
      end
    end
  end

  // Frame-level arbitration FSM: next state, pending set/clear, pointer advance.
  always_comb begin
    state_nxt      = state;
    rr_ptr_nxt     = rr_ptr;
    lock_port_nxt  = lock_port;
    first_beat_nxt = first_beat;
    pending_nxt    = pending;
    case (state)
      IDLE: begin
        pending_nxt = pending | rx_sof_i;
        if (sel_found) begin
          state_nxt             = LOCK;
          lock_port_nxt         = sel_port;
          first_beat_nxt        = 1'b1;
          pending_nxt[sel_port] = 1'b0;
        end
      end
      LOCK: begin
        pending_nxt = pending | (rx_sof_i & ~lock_mask);
        if (accept) first_beat_nxt = 1'b0;
        if (viol) begin
          // A new sof mid-frame aborts this frame and re-queues the port.
          pending_nxt[lock_port] = 1'b1;
          rr_ptr_nxt             = wrap_add(lock_port, 1);
          state_nxt              = IDLE;
        end else if (eof_acc || wdog_trip) begin
          rr_ptr_nxt = wrap_add(lock_port, 1);
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge switch_clk or negedge switch_rst_n) begin
    if (!switch_rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      lock_port  <= '0;
      first_beat <= 1'b0;
      pending    <= '0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_ptr_nxt;
      lock_port  <= lock_port_nxt;
      first_beat <= first_beat_nxt;
      pending    <= pending_nxt;
    end
  end

  // ---- stage boundary: accepted beat -> memory output register ----
  // Strobes pulse for one cycle; data, port and error hold between events.
  always_ff @(posedge switch_clk or negedge switch_rst_n) begin
    if (!switch_rst_n) begin
      mem_valid_o <= 1'b0;
      mem_sof_o   <= 1'b0;
      mem_eof_o   <= 1'b0;
      mem_error_o <= 1'b0;
      mem_data_o  <= '0;
      mem_port_o  <= '0;
    end else begin
      mem_valid_o <= accept && !viol;
      mem_sof_o   <= accept && !viol && first_beat;
      mem_eof_o   <= eof_acc || viol || wdog_trip;
      if (accept && !viol) mem_data_o <= lk_data;
      if (accept || wdog_trip) mem_port_o <= lock_port;
      if (eof_acc) mem_error_o <= lk_err;
      else if (viol || wdog_trip) mem_error_o <= 1'b1;
    end
  end

`ifdef RX_ARB_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);

  logic [WW-1:0] wdog_cnt;
  logic [15:0]   wdog_trip_count;

  // Trip once WDOG_CYCLES ready cycles pass without an accepted beat.
  assign wdog_trip = (state == LOCK) && (wdog_cnt == WW'(WDOG_CYCLES));

  // Idle-beat counter: cleared outside LOCK and on every accepted beat,
  // frozen while memory back-pressures.
  always_ff @(posedge switch_clk or negedge switch_rst_n) begin
    if (!switch_rst_n) begin
      wdog_cnt <= '0;
    end else if (state != LOCK || accept) begin
      wdog_cnt <= '0;
    end else if (mem_ready_i && !wdog_trip) begin
      wdog_cnt <= wdog_cnt + 1'b1;
    end
  end

  // Saturating count of watchdog aborts.
  always_ff @(posedge switch_clk or negedge switch_rst_n) begin
    if (!switch_rst_n) begin
      wdog_trip_count <= '0;
    end else if (wdog_trip && wdog_trip_count != 16'hFFFF) begin
      wdog_trip_count <= wdog_trip_count + 16'd1;
    end
  end
`else
  logic unused_wdog;
  assign wdog_trip   = 1'b0;
  assign unused_wdog = (WDOG_CYCLES > 0);
`endif

endmodule
